// File: rtl/nibble_tx.sv
// nibble_tx: buffers nibbles written to the CPU out port in a small FIFO and
// shifts each one out as a 7-bit frame: start(0), D[0..3] LSB first,
// even parity, stop(1). Every bit is held CLKS_PER_BIT clocks.
module nibble_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     loadOut,
  input  logic [3:0]               D,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    BIT_RELOAD = 8'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic [1:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          push, pop;
  logic [3:0]    head;

  // Next-state logic for FIFO bookkeeping and the frame sequencer.
  always_comb begin
    // Fullness is judged on the pre-edge count; a same-edge pop does not
    // make room for the write.
    push       = loadOut && (count_q != DEPTH_C);
    pop        = 1'b0;
    head       = mem_q[rd_ptr_q];
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (timer_q == 8'd0) begin
          state_d   = S_DATA;
          bit_idx_d = 2'd0;
          timer_d   = BIT_RELOAD;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_DATA: begin
        if (timer_q == 8'd0) begin
          shift_d = {1'b0, shift_q[3:1]};
          timer_d = BIT_RELOAD;
          if (bit_idx_q == 2'd3) begin
            state_d = S_PARITY;
            tx_d    = parity_q;
          end else begin
            bit_idx_d = bit_idx_q + 2'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_PARITY: begin
        if (timer_q == 8'd0) begin
          state_d = S_STOP;
          timer_d = BIT_RELOAD;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_STOP: begin
        if (timer_q == 8'd0) begin
          // Chain straight into the next start bit when data is waiting.
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            timer_d = BIT_RELOAD;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      state_d   = S_START;
      timer_d   = BIT_RELOAD;
      bit_idx_d = 2'd0;
      shift_d   = head;
      parity_d  = ^head;
      tx_d      = 1'b0;
    end

    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (loadOut & ~push);
  end

  // Control and datapath registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
      bit_idx_q  <= 2'd0;
      shift_q    <= 4'd0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  // FIFO storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= D;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE) || (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_nibble_tx.sv
// tb_nibble_tx: directed stimulus with a queue-based model of the serial
// line, compared every cycle, plus hand-computed frame and timing checks.
module tb_nibble_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, Rst, loadOut;
  logic [3:0]    D;
  logic          tx, busy, full, overflow;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  nibble_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .Rst(Rst), .loadOut(loadOut), .D(D),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow), .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, serial line as a queue of per-cycle tx values.
  logic [3:0] m_fifo[$];
  bit         m_line[$];
  bit         m_ovf = 0, m_tx = 1, m_inframe = 0;

  always @(posedge clk or negedge Rst) begin
    int pre;
    logic [3:0] h;
    bit fb[7];
    if (!Rst) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf = 0; m_tx = 1; m_inframe = 0;
    end else begin
      pre = m_fifo.size();
      if (pre != 0 && m_line.size() == 0) begin
        h = m_fifo.pop_front();
        fb[0] = 0; fb[1] = h[0]; fb[2] = h[1]; fb[3] = h[2]; fb[4] = h[3];
        fb[5] = ^h; fb[6] = 1;
        for (int i = 0; i < 7; i++)
          for (int c = 0; c < CPB; c++) m_line.push_back(fb[i]);
      end
      if (loadOut) begin
        if (pre == DEPTH) m_ovf = 1;
        else m_fifo.push_back(D);
      end
      if (m_line.size() != 0) begin
        m_tx = m_line.pop_front();
        m_inframe = 1;
      end else begin
        m_tx = 1;
        m_inframe = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", tx, m_tx);
      chk("busy", busy, (m_inframe || (m_fifo.size() != 0)));
      chk("count", count, m_fifo.size());
      chk("full", full, (m_fifo.size() == DEPTH));
      chk("overflow", overflow, m_ovf);
    end
  end

  // Capture one full frame starting at the next negedge; bits MSB = start bit.
  task automatic frame_chk(input string name, input logic [6:0] bits);
    logic [27:0] cap, exp;
    cap = '0; exp = '0;
    for (int b = 0; b < 7; b++)
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        cap[27 - (b*CPB + c)] = tx;
        exp[27 - (b*CPB + c)] = bits[6 - b];
      end
    chk(name, cap, exp);
  endtask

  task automatic send1(input logic [3:0] d, input string name, input logic [6:0] bits);
    @(negedge clk); loadOut = 1; D = d;
    @(negedge clk); loadOut = 0;
    chk({name, "_pre_tx"}, tx, 1);
    chk({name, "_pre_cnt"}, count, 1);
    frame_chk(name, bits);
    chk({name, "_busy_stop"}, busy, 1);
    @(negedge clk);
    chk({name, "_busy_fall"}, busy, 0);
  endtask

  task automatic wait_idle(input string name, input int expect_cyc);
    int cyc;
    cyc = 0;
    while (busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, cyc, expect_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 0; loadOut = 1; D = 4'hF;
    repeat (2) @(negedge clk);
    chk_en = 1;
    repeat (4) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    loadOut = 0;
    #2 Rst = 1;
    repeat (2) @(negedge clk);

    // Single frames: 1011 -> 0,1,1,0,1,p=1,1 ; 0000 -> p=0 ; 0111 -> p=1
    send1(4'b1011, "frame_1011", 7'b0110111);
    send1(4'b0000, "frame_0000", 7'b0000001);
    send1(4'b0111, "frame_0111", 7'b0111011);

    // Burst of six writes into a 4-deep FIFO.
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); loadOut = 1; D = 4'(i);
      if (i == 3) begin
        chk("burst_pop1_cnt", count, 1);
        chk("burst_pop1_tx", tx, 0);
      end
    end
    @(negedge clk); loadOut = 0;
    chk("burst_count", count, 4);
    chk("burst_full", full, 1);
    chk("burst_ovf", overflow, 1);
    // Five contiguous frames from pop edge 2 end at edge 142; we are after edge 6.
    wait_idle("burst_len", 136);
    chk("burst_cnt_end", count, 0);
    chk("burst_ovf_end", overflow, 1);

    // Push on pop edges: from IDLE, then on the last STOP cycle.
    @(negedge clk); loadOut = 1; D = 4'hA;
    @(negedge clk); D = 4'h5;
    @(negedge clk); loadOut = 0;
    chk("pp_idle_cnt", count, 1);
    chk("pp_idle_tx", tx, 0);
    repeat (27) @(negedge clk);
    loadOut = 1; D = 4'hC;
    @(negedge clk); loadOut = 0;
    chk("pp_stop_cnt", count, 1);
    chk("pp_stop_tx", tx, 0);
    wait_idle("pp_len", 56);

    // Reset during DATA bit 2 with two entries queued.
    @(negedge clk); loadOut = 1; D = 4'h9;
    @(negedge clk); D = 4'h6;
    @(negedge clk); D = 4'h3;
    @(negedge clk); loadOut = 0;
    chk("mid_cnt", count, 2);
    repeat (12) @(negedge clk);
    chk("mid_pre_tx", tx, 0);
    #2 Rst = 0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 Rst = 1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_tx", tx, 1);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_tx.md
# nibble_tx

Serial transmitter for the CPU's 4-bit output port. It takes the same write strobe and data bus that load the out port (loadOut plus the tri-state bus value) and buffers each written nibble in a small FIFO. It shifts each nibble out on a single line as a framed, parity-protected serial word. It lets a NibblER program stream results off-chip without stalling, even though the CPU has no handshake back from the port.

## Interface
Parameters:
- CLKS_PER_BIT, 4: clk cycles each serial bit is held; legal range 1..255.
- DEPTH, 4: FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-low. Rst=0 forces reset state immediately.
- loadOut  in  1  write strobe from the microcode (out-port load), sampled every rising edge.
- D  in  4  data bus value written with loadOut.
- tx  out  1  serial line; idles high.
- busy  out  1  1 while a frame is on the line or the FIFO is non-empty.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; set when a write is dropped.
- count  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
- Frame is 7 bits, each held CLKS_PER_BIT cycles, in this order:
  - start bit 0;
  - D[0], D[1], D[2], D[3] (LSB first);
  - even parity bit (^D);
  - stop bit 1.
- Push: at an edge with loadOut=1 and pre-edge count < DEPTH, D is written at the write pointer. The pointer advances and wraps modulo DEPTH.
- Drop: loadOut=1 with pre-edge count == DEPTH drops the write. overflow is set and stays set until reset. A pop on the same edge does not rescue the write; full is judged on pre-edge count.
- Pop: the FSM pops the head entry on the edge where it leaves IDLE or STOP toward START. The read pointer wraps modulo DEPTH.
- Simultaneous push and pop at count < DEPTH: count is unchanged and both pointers advance.
- FSM states:
  - IDLE: tx=1. If count != 0, pop the head, load the 4-bit shift register, compute parity, and go to START.
  - START: tx=0, held CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], held CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit index 3, go to PARITY.
  - PARITY: tx=parity, held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1, held CLKS_PER_BIT cycles. On the last cycle, if count != 0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit timing uses one down-counter reloaded to CLKS_PER_BIT-1 on every state or bit change.
- tx is registered; there are no combinational paths from inputs to tx.
- busy = (state != IDLE) || (count != 0). full = (count == DEPTH). Both are combinational from registers.
- Reset state: tx=1, busy=0, full=0, overflow=0, count=0, FSM in IDLE, both pointers 0, shift register 0, bit counter 0. FIFO contents need no reset.
- Reset mid-frame: the frame is aborted, tx returns high asynchronously, and buffered entries are discarded.

## Timing
- Write at edge k (loadOut=1, FSM IDLE, count 0): count=1 after edge k. The FSM pops at edge k+1, so count=0 and tx=0 after edge k+1.
- Latency from the sampling edge to the start bit on tx: 1 cycle.
- Frame length: 7*CLKS_PER_BIT cycles, which is 28 at default.
- Back-to-back frames are contiguous: the stop bit's last cycle is followed directly by the next start bit.
- overflow rises after the dropping edge.
- Release of Rst (0 to 1) is asynchronous. The first functional edge is the first rising clk with Rst=1.

## Test plan
- Reset: hold Rst=0 with toggling clk and loadOut=1 -> tx=1, busy=0, full=0, overflow=0, count=0 throughout.
- Single nibble: D=4'b1011, one-cycle loadOut, CLKS_PER_BIT=4 -> tx gives 0,1,1,0,1,1(parity),1, each bit 4 cycles. The start bit begins 1 cycle after the write edge. busy falls after 28 cycles of frame.
- Parity zero case: D=4'b0000 -> data bits all 0, parity 0, stop 1. D=4'b0111 -> parity 1.
- Burst and overflow, DEPTH=4: loadOut=1 on 6 consecutive edges with D=1,2,3,4,5,6.
  - Nibble 1 is popped after the second edge.
  - count reaches 4 (full=1); nibble 6 is dropped and overflow=1.
  - tx then carries frames 1..5 contiguously over 140 cycles, then returns to IDLE with count=0. overflow stays 1.
- Simultaneous push/pop: write a second nibble on the exact edge the FSM pops the first (the last STOP cycle) -> count stays 1, and that nibble is sent next with no gap.
- Reset mid-frame: assert Rst=0 during the DATA bit 2 of a frame with 2 entries queued -> tx=1 immediately and count=0. After release, no frame is sent until a new write.
